// File: rtl/mux_32x8_serializer_if.sv
// Word-in / byte-out bus of the 32-to-8 serializer.
interface mux_32x8_serializer_if #(
   parameter int OUT_W = 8,
   parameter int LANES = 4,
   parameter int SEL_W = 2
);
   logic [OUT_W*LANES-1:0] data_in_32x8;
   logic                   valid_in_32x8;
   logic                   ready_out_32x8;
   logic [OUT_W-1:0]       data_out_32x8;
   logic                   valid_out_32x8;
   logic [SEL_W-1:0]       selector_clk_4f;
   logic [7:0]             words_sent;

   modport master (
      output data_in_32x8,
      output valid_in_32x8,
      input  ready_out_32x8,
      input  data_out_32x8,
      input  valid_out_32x8,
      input  selector_clk_4f,
      input  words_sent
   );

   modport slave (
      input  data_in_32x8,
      input  valid_in_32x8,
      output ready_out_32x8,
      output data_out_32x8,
      output valid_out_32x8,
      output selector_clk_4f,
      output words_sent
   );
endinterface

// File: rtl/mux_32x8_serializer.sv
// Serializes 32-bit words into MSB-first bytes with a lane selector.
// One word is being shifted out while a second can wait in pending,
// so a producer holding valid high sees a bubble-free byte stream.
//
// state | meaning
// IDLE  | nothing to send, valid_out low, waiting for a word
// SEND  | emitting bytes of the shift register, cnt = lane in flight
module mux_32x8_serializer #(
   parameter int OUT_W = 8,
   parameter int LANES = 4,
   parameter int SEL_W = 2
) (
   input  logic                  clk_4f,
   input  logic                  reset,
   mux_32x8_serializer_if.slave  bus
);
   localparam int W = OUT_W * LANES;
   localparam logic [SEL_W-1:0] LAST = SEL_W'(LANES - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t           state_q, state_d;
   logic [SEL_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     shift_q, shift_d;
   logic [W-1:0]     pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic [OUT_W-1:0] dout_q, dout_d;
   logic             vout_q, vout_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [7:0]       sent_q, sent_d;
   logic             xfer;

   // State and datapath registers; reset discards any word in flight.
   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         dout_q     <= '0;
         vout_q     <= 1'b0;
         sel_q      <= '0;
         sent_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         dout_q     <= dout_d;
         vout_q     <= vout_d;
         sel_q      <= sel_d;
         sent_q     <= sent_d;
      end
   end

   // Next state: byte emission, word reload and pending capture.
   // The shift register moves left each byte so the lane in flight is
   // always the top byte.
   always_comb begin
      xfer       = bus.valid_in_32x8 && !pend_vld_q;
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      dout_d     = dout_q;
      vout_d     = vout_q;
      sel_d      = sel_q;
      sent_d     = sent_q;
      case (state_q)
         IDLE: begin
            vout_d = 1'b0;
            sel_d  = '0;
            if (xfer) begin
               shift_d = bus.data_in_32x8;
               cnt_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            dout_d  = shift_q[W-1 -: OUT_W];
            sel_d   = cnt_q;
            vout_d  = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            shift_d = {shift_q[W-OUT_W-1:0], {OUT_W{1'b0}}};
            if (cnt_q == LAST) begin
               sent_d = sent_q + 8'd1;
               cnt_d  = '0;
               if (pend_vld_q) begin
                  shift_d    = pend_q;
                  pend_vld_d = 1'b0;
               end else if (xfer) begin
                  shift_d = bus.data_in_32x8;
               end else begin
                  state_d = IDLE;
               end
            end else if (xfer) begin
               pend_d     = bus.data_in_32x8;
               pend_vld_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs straight from registers; ready only depends on pending.
   always_comb begin
      bus.ready_out_32x8  = !pend_vld_q;
      bus.data_out_32x8   = dout_q;
      bus.valid_out_32x8  = vout_q;
      bus.selector_clk_4f = sel_q;
      bus.words_sent      = sent_q;
   end
endmodule

// File: tb/tb_mux_32x8_serializer.sv
// Bench for the 32-to-8 serializer: word scoreboard plus per-scenario tasks.
module tb_mux_32x8_serializer;
   logic clk_4f = 1'b0;
   logic reset  = 1'b1;

   mux_32x8_serializer_if bus ();

   mux_32x8_serializer dut (
      .clk_4f (clk_4f),
      .reset  (reset),
      .bus    (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          lane     = 0;
   int          sent_model = 0;
   logic [31:0] exp_q[$];
   logic [7:0]  mon_eb;

   always #5 clk_4f = ~clk_4f;

   // Record every accepted word.
   always @(posedge clk_4f) begin
      cyc++;
      if (!reset && bus.valid_in_32x8 && bus.ready_out_32x8)
         exp_q.push_back(bus.data_in_32x8);
   end

   // Reassemble bytes by lane (the downstream demux view) and compare.
   always @(negedge clk_4f) begin
      if (!reset && bus.valid_out_32x8) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: byte %h sel %0d, required no byte",
                     bus.data_out_32x8, bus.selector_clk_4f);
         end else begin
            mon_eb = 8'(exp_q[0] >> (8 * (3 - lane)));
            if (bus.data_out_32x8 !== mon_eb || bus.selector_clk_4f !== 2'(lane)) begin
               n_fail++;
               $display("FAIL sb_byte: got %h sel %0d, required %h sel %0d (word %h)",
                        bus.data_out_32x8, bus.selector_clk_4f, mon_eb, lane, exp_q[0]);
            end
            if (lane == 3) begin
               void'(exp_q.pop_front());
               lane = 0;
               sent_model++;
               n_checks++;
               if (bus.words_sent !== 8'(sent_model)) begin
                  n_fail++;
                  $display("FAIL sb_words_sent: got %0d, required %0d",
                           bus.words_sent, 8'(sent_model));
               end
            end else begin
               lane++;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      reset = 1'b1;
      bus.valid_in_32x8 = 1'b0;
      bus.data_in_32x8  = '0;
      exp_q.delete();
      lane = 0;
      sent_model = 0;
      repeat (2) @(posedge clk_4f);
      #1 reset = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, output int acc_cyc);
      int t = 0;
      bus.data_in_32x8  = w;
      bus.valid_in_32x8 = 1'b1;
      while (!bus.ready_out_32x8 && t < 50) begin
         @(posedge clk_4f);
         #1;
         t++;
      end
      if (t >= 50) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: ready stayed %b, required 1", bus.ready_out_32x8);
         bus.valid_in_32x8 = 1'b0;
         acc_cyc = -1;
         return;
      end
      @(posedge clk_4f);
      #1;
      acc_cyc = cyc;
      bus.valid_in_32x8 = 1'b0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((exp_q.size() != 0 || bus.valid_out_32x8) && t < 3000) begin
         @(negedge clk_4f);
         t++;
      end
      n_checks++;
      if (t >= 3000) begin
         n_fail++;
         $display("FAIL drain_timeout: %0d words left, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.valid_in_32x8 = 1'b0;
      bus.data_in_32x8  = '0;
      #2;
      n_checks += 4;
      if (bus.data_out_32x8 !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h, required 00", bus.data_out_32x8); end
      if (bus.valid_out_32x8 !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", bus.valid_out_32x8); end
      if (bus.selector_clk_4f !== 2'b00) begin n_fail++; $display("FAIL rst_sel: got %b, required 00", bus.selector_clk_4f); end
      if (bus.words_sent !== 8'd0) begin n_fail++; $display("FAIL rst_words: got %0d, required 0", bus.words_sent); end
      do_reset();
      n_checks++;
      if (bus.ready_out_32x8 !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b, required 1", bus.ready_out_32x8); end
   endtask

   task automatic test_single();
      int a;
      logic [31:0] w = 32'hAABBCCDD;
      logic [7:0] eb;
      send_word(w, a);
      @(negedge clk_4f);
      n_checks++;
      if (bus.valid_out_32x8 !== 1'b0) begin n_fail++; $display("FAIL single_latency: valid %b before byte 0 edge, required 0", bus.valid_out_32x8); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_4f);
         eb = 8'(w >> (8 * (3 - i)));
         n_checks++;
         if (bus.data_out_32x8 !== eb || bus.selector_clk_4f !== 2'(i) || bus.valid_out_32x8 !== 1'b1) begin
            n_fail++;
            $display("FAIL single_byte%0d: got %h sel %0d valid %b, required %h sel %0d valid 1",
                     i, bus.data_out_32x8, bus.selector_clk_4f, bus.valid_out_32x8, eb, i);
         end
      end
      @(negedge clk_4f);
      n_checks += 2;
      if (bus.valid_out_32x8 !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b, required 0", bus.valid_out_32x8); end
      if (bus.words_sent !== 8'd1) begin n_fail++; $display("FAIL single_words: got %0d, required 1", bus.words_sent); end
   endtask

   task automatic test_back_to_back();
      int a;
      int base = sent_model;
      int good = 0;
      int t = 0;
      logic saw_low = 1'b0;
      fork
         begin
            send_word(32'h01020304, a);
            send_word(32'h05060708, a);
            send_word(32'h090A0B0C, a);
         end
         begin
            @(negedge clk_4f);
            while (!bus.valid_out_32x8 && t < 20) begin
               @(negedge clk_4f);
               t++;
            end
            for (int i = 0; i < 12; i++) begin
               if (bus.valid_out_32x8) good++;
               if (!bus.ready_out_32x8) saw_low = 1'b1;
               if (i < 11) @(negedge clk_4f);
            end
         end
      join
      wait_drain();
      n_checks += 3;
      if (good != 12) begin n_fail++; $display("FAIL b2b_gapless: got %0d valid bytes in window, required 12", good); end
      if (saw_low !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_low: got %b, required 1", saw_low); end
      if (bus.words_sent !== 8'(base + 3)) begin n_fail++; $display("FAIL b2b_words: got %0d, required %0d", bus.words_sent, 8'(base + 3)); end
   endtask

   task automatic test_backpressure();
      int a1, a2, a3;
      send_word(32'h1A1B1C1D, a1);
      send_word(32'h2A2B2C2D, a2);
      send_word(32'h3A3B3C3D, a3);
      n_checks += 2;
      if (a2 - a1 != 1) begin n_fail++; $display("FAIL bp_accept2: got %0d cycles after word 1, required 1", a2 - a1); end
      if (a3 - a1 != 5) begin n_fail++; $display("FAIL bp_accept3: got %0d cycles after word 1, required 5", a3 - a1); end
      wait_drain();
   endtask

   task automatic test_mid_reset();
      int a;
      int t = 0;
      int bad = 0;
      do_reset();
      send_word(32'hAABBCCDD, a);
      @(negedge clk_4f);
      while (!(bus.valid_out_32x8 && bus.data_out_32x8 == 8'hBB) && t < 20) begin
         @(negedge clk_4f);
         t++;
      end
      n_checks++;
      if (t >= 20) begin n_fail++; $display("FAIL midrst_no_bb: byte BB not seen, required seen"); end
      #1 reset = 1'b1;
      exp_q.delete();
      lane = 0;
      sent_model = 0;
      #1;
      n_checks++;
      if (bus.data_out_32x8 !== 8'h00 || bus.valid_out_32x8 !== 1'b0 ||
          bus.selector_clk_4f !== 2'b00 || bus.words_sent !== 8'd0) begin
         n_fail++;
         $display("FAIL midrst_async: got data %h valid %b sel %b words %0d, required all zero",
                  bus.data_out_32x8, bus.valid_out_32x8, bus.selector_clk_4f, bus.words_sent);
      end
      repeat (3) begin
         @(negedge clk_4f);
         if (bus.valid_out_32x8 !== 1'b0) bad++;
      end
      @(posedge clk_4f);
      #1 reset = 1'b0;
      repeat (2) begin
         @(negedge clk_4f);
         if (bus.valid_out_32x8 !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL midrst_leftover: got %0d stray valid cycles, required 0", bad); end
      send_word(32'h11223344, a);
      wait_drain();
      n_checks++;
      if (bus.words_sent !== 8'd1) begin n_fail++; $display("FAIL midrst_words: got %0d, required 1", bus.words_sent); end
   endtask

   task automatic test_wrap();
      int a;
      do_reset();
      for (int i = 0; i < 256; i++) send_word($urandom, a);
      wait_drain();
      n_checks++;
      if (bus.words_sent !== 8'd0) begin n_fail++; $display("FAIL wrap_words: got %0d, required 0", bus.words_sent); end
   endtask

   task automatic test_loopback();
      int a;
      int base = sent_model;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 5)) @(posedge clk_4f);
         #1;
         send_word($urandom, a);
      end
      wait_drain();
      n_checks++;
      if (bus.words_sent !== 8'(base + 40)) begin n_fail++; $display("FAIL loop_words: got %0d, required %0d", bus.words_sent, 8'(base + 40)); end
   endtask

   initial begin
      bus.valid_in_32x8 = 1'b0;
      bus.data_in_32x8  = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_mid_reset();
      test_wrap();
      test_loopback();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mux_32x8_serializer.md
Name: mux_32x8_serializer

Overview:
- Upstream feeder for the 8-bit-to-32-bit demux stage, in the clk_4f domain.
- Accepts 32-bit words through a valid/ready handshake and emits each word as 4 bytes, MSB first, on consecutive clk_4f cycles.
- Generates the byte-lane selector and byte valid that the downstream demux consumes.
- Holds one word being sent plus one pending word, so a producer can sustain gapless traffic.

Parameters:
- OUT_W, 8, byte width.
- LANES, 4, bytes per word; input width is OUT_W*LANES.
- SEL_W, 2, selector width, log2(LANES).

Ports:
- clk_4f  input  1  clock, 4x word rate.
- reset  input  1  asynchronous, active-high reset.
- data_in_32x8  input  32  word to serialize.
- valid_in_32x8  input  1  data_in_32x8 is valid.
- ready_out_32x8  output  1  block can take a word this cycle.
- data_out_32x8  output  8  current byte.
- valid_out_32x8  output  1  data_out_32x8 is a real byte.
- selector_clk_4f  output  2  lane index of the current byte; 00 = bits [31:24], 11 = bits [7:0].
- words_sent  output  8  count of fully emitted words, wraps 255->0.

Behaviour:
- Reset (asynchronous, takes effect immediately, even mid-word):
  - data_out_32x8=0, valid_out_32x8=0, selector_clk_4f=00, words_sent=0.
  - Shift and pending registers cleared; pending_valid=0; state=IDLE.
  - ready_out_32x8=1 while reset is deasserted and pending is empty.
  - A partially sent word is discarded; no further bytes of it appear.
- Handshake:
  - Transfer happens at a rising edge when valid_in_32x8 && ready_out_32x8.
  - ready_out_32x8 = !pending_valid (combinational from a register).
  - data_in_32x8 is ignored when no transfer occurs.
- States IDLE and SEND; internal 2-bit lane counter cnt.
- IDLE:
  - valid_out_32x8=0, selector_clk_4f=00, data_out_32x8 holds its last value.
  - On transfer: word loads into the shift register, cnt=00, next state SEND.
  - Latency: word accepted at edge N; byte 0 ([31:24]) is visible with valid=1 and sel=00 after edge N+1.
- SEND, each edge:
  - Outputs are registered: data_out_32x8 = shift[cnt], selector_clk_4f = cnt, valid_out_32x8 = 1.
  - cnt increments 00->01->10->11.
  - A transfer while SEND with pending empty stores the word in pending and sets pending_valid=1.
- End of word (edge at which the byte for cnt=11 is emitted):
  - words_sent increments.
  - If pending_valid: pending moves to the shift register, pending_valid clears, cnt=00, stay in SEND (gapless next word).
  - Else, if a transfer happens on this edge: the incoming word goes straight to the shift register, stay in SEND (gapless).
  - Else: next state IDLE, and valid_out_32x8 drops after the following edge.
- Simultaneous events:
  - At end of word with pending full, ready=0, so no new word can collide.
  - The edge that empties pending raises ready for the following cycle only.
- Throughput: max 1 word per 4 cycles; the output byte stream has no bubbles while words are available.
- Byte order per word is strictly [31:24], [23:16], [15:8], [7:0]; selector_clk_4f always matches the lane of data_out_32x8 in the same cycle.
- No byte is ever dropped or duplicated except on reset.

Test Plan:
- Reset then one word: release reset, send 0xAABBCCDD once -> after accept edge N:
  - bytes AA, BB, CC, DD at N+1..N+4 with sel 00, 01, 10, 11 and valid=1.
  - valid=0 from N+5; words_sent=1.
- Back-to-back: valid_in held high with 0x01020304, 0x05060708, 0x090A0B0C -> 12 consecutive valid bytes 01..0C with no gap.
  - ready low while pending is full; words_sent=3.
- Backpressure: offer 3 words in 3 consecutive cycles -> word 1 to shift, word 2 to pending, word 3 held with ready=0 until the edge ending word 1.
  - Output order is 1, 2, 3 and none is lost.
- Mid-word reset: assert reset after byte BB of 0xAABBCCDD -> outputs zero immediately, CC/DD never appear.
  - After release, 0x11223344 emits 11, 22, 33, 44 correctly.
- Wrap: stream 256 words -> words_sent returns to 0; lane order stays correct throughout.
- Loopback: connect to the 8-to-32 demux with random words and gaps -> demux output equals input word stream.
